// File: rtl/move_commit_unit_pkg.sv
// Shared cell/state encodings and helpers for the 4x4 tic-tac-toe board writer.
package move_commit_unit_pkg;

   localparam int unsigned NumCells = 16;

   localparam logic [1:0] CellEmpty    = 2'b00;
   localparam logic [1:0] CellPlayer   = 2'b01;
   localparam logic [1:0] CellComputer = 2'b10;

   typedef logic [NumCells-1:0][1:0] board_t;

   typedef enum logic [2:0] {
      StPlTurn  = 3'd0,
      StPlCheck = 3'd1,
      StPcTurn  = 3'd2,
      StPcCheck = 3'd3,
      StFull    = 3'd4
   } state_e;

   // One bit per cell, set when the cell holds any mark.
   function automatic logic [NumCells-1:0] occupied(input board_t cells);
      logic [NumCells-1:0] occ;
      for (int k = 0; k < NumCells; k++) begin
         occ[k] = |cells[k];
      end
      return occ;
   endfunction

endpackage

// File: rtl/move_commit_unit_cell_index_decoder.sv
// Combinational 4-bit cell index to 16-bit one-hot enable.
module move_commit_unit_cell_index_decoder
   import move_commit_unit_pkg::*;
(
   input  logic [3:0]          idx_i,
   output logic [NumCells-1:0] onehot_o
);

   assign onehot_o = NumCells'(1) << idx_i;

endmodule

// File: rtl/move_commit_unit.sv
// Board-state writer: accepts player/computer moves, checks emptiness, commits cells and turns.
// Optional player-turn timeout is built only when MOVE_TIMEOUT_EN is defined.
module move_commit_unit
   import move_commit_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                clock_i,
   input  logic                reset_n_i,
   input  logic                clear_i,
   input  logic                pl_valid_i,
   input  logic [3:0]          pl_idx_i,
   output logic                pl_ready_o,
   input  logic                pc_valid_i,
   input  logic [3:0]          pc_idx_i,
   output logic                pc_ready_o,
   output logic [NumCells-1:0] PL_en_o,
   output logic [NumCells-1:0] PC_en_o,
   output logic [1:0]          pos1_o,
   output logic [1:0]          pos2_o,
   output logic [1:0]          pos3_o,
   output logic [1:0]          pos4_o,
   output logic [1:0]          pos5_o,
   output logic [1:0]          pos6_o,
   output logic [1:0]          pos7_o,
   output logic [1:0]          pos8_o,
   output logic [1:0]          pos9_o,
   output logic [1:0]          pos10_o,
   output logic [1:0]          pos11_o,
   output logic [1:0]          pos12_o,
   output logic [1:0]          pos13_o,
   output logic [1:0]          pos14_o,
   output logic [1:0]          pos15_o,
   output logic [1:0]          pos16_o,
   output logic                turn_o,
   output logic                illegal_o,
   output logic                board_full_o,
   output logic                timeout_o
);

   state_e              state_q, state_d;
   board_t              cells_q, cells_d;
   logic [NumCells-1:0] pl_en_q, pl_en_d, pc_en_q, pc_en_d;
   logic [NumCells-1:0] dec_onehot;
   logic [3:0]          dec_idx;
   logic                turn_q, turn_d;
   logic                illegal_q, illegal_d;
   logic                full_q, full_d;
   logic                tmo_hit;

   assign dec_idx = (state_q == StPcTurn) ? pc_idx_i : pl_idx_i;

   move_commit_unit_cell_index_decoder u_dec (
      .idx_i    (dec_idx),
      .onehot_o (dec_onehot)
   );

`ifdef MOVE_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Counter reads zero in the first cycle of every player turn.
   assign cnt_d   = (state_q == StPlTurn && !clear_i) ? cnt_q + CntW'(1) : '0;
   assign tmo_hit = (state_q == StPlTurn) && !pl_valid_i && !clear_i &&
                    (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) cnt_q <= '0;
      else            cnt_q <= cnt_d;
   end
`else
   logic unused_timeout_cycles;
   assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
   assign tmo_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      cells_d   = cells_q;
      pl_en_d   = '0;
      pc_en_d   = '0;
      turn_d    = turn_q;
      illegal_d = 1'b0;
      full_d    = full_q;
      unique case (state_q)
         StPlTurn: begin
            if (pl_valid_i) begin
               pl_en_d = dec_onehot;
               state_d = StPlCheck;
            end else if (tmo_hit) begin
               turn_d  = 1'b1;
               state_d = StPcTurn;
            end
         end
         StPlCheck: begin
            // Decision uses the pre-write board; the write lands at this edge.
            if (|(occupied(cells_q) & pl_en_q)) begin
               illegal_d = 1'b1;
               state_d   = StPlTurn;
            end else begin
               for (int k = 0; k < NumCells; k++) begin
                  if (pl_en_q[k]) cells_d[k] = CellPlayer;
               end
               turn_d  = 1'b1;
               full_d  = &occupied(cells_d);
               state_d = full_d ? StFull : StPcTurn;
            end
         end
         StPcTurn: begin
            if (pc_valid_i) begin
               pc_en_d = dec_onehot;
               state_d = StPcCheck;
            end
         end
         StPcCheck: begin
            if (|(occupied(cells_q) & pc_en_q)) begin
               illegal_d = 1'b1;
               state_d   = StPcTurn;
            end else begin
               for (int k = 0; k < NumCells; k++) begin
                  if (pc_en_q[k]) cells_d[k] = CellComputer;
               end
               turn_d  = 1'b0;
               full_d  = &occupied(cells_d);
               state_d = full_d ? StFull : StPlTurn;
            end
         end
         StFull:  ;
         default: state_d = StPlTurn;
      endcase
      if (clear_i) begin
         state_d   = StPlTurn;
         cells_d   = '0;
         pl_en_d   = '0;
         pc_en_d   = '0;
         turn_d    = 1'b0;
         illegal_d = 1'b0;
         full_d    = 1'b0;
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q   <= StPlTurn;
         cells_q   <= '0;
         pl_en_q   <= '0;
         pc_en_q   <= '0;
         turn_q    <= 1'b0;
         illegal_q <= 1'b0;
         full_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cells_q   <= cells_d;
         pl_en_q   <= pl_en_d;
         pc_en_q   <= pc_en_d;
         turn_q    <= turn_d;
         illegal_q <= illegal_d;
         full_q    <= full_d;
      end
   end

   assign pl_ready_o   = (state_q == StPlTurn);
   assign pc_ready_o   = (state_q == StPcTurn);
   assign PL_en_o      = pl_en_q;
   assign PC_en_o      = pc_en_q;
   assign turn_o       = turn_q;
   assign illegal_o    = illegal_q;
   assign board_full_o = full_q;
   assign timeout_o    = tmo_hit;

   assign pos1_o  = cells_q[0];
   assign pos2_o  = cells_q[1];
   assign pos3_o  = cells_q[2];
   assign pos4_o  = cells_q[3];
   assign pos5_o  = cells_q[4];
   assign pos6_o  = cells_q[5];
   assign pos7_o  = cells_q[6];
   assign pos8_o  = cells_q[7];
   assign pos9_o  = cells_q[8];
   assign pos10_o = cells_q[9];
   assign pos11_o = cells_q[10];
   assign pos12_o = cells_q[11];
   assign pos13_o = cells_q[12];
   assign pos14_o = cells_q[13];
   assign pos15_o = cells_q[14];
   assign pos16_o = cells_q[15];

endmodule

// File: tb/tb_move_commit_unit.sv
// Directed self-checking bench for move_commit_unit (timeout checks follow MOVE_TIMEOUT_EN).
module tb_move_commit_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        pl_valid, pc_valid;
   logic [3:0]  pl_idx, pc_idx;
   logic        pl_ready, pc_ready;
   logic [15:0] pl_en, pc_en;
   logic [1:0]  pos [16];
   logic        turn, illegal, board_full, timeout;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   move_commit_unit #(.TIMEOUT_CYCLES(8)) dut (
      .clock_i      (clk),
      .reset_n_i    (rst_n),
      .clear_i      (clear),
      .pl_valid_i   (pl_valid),
      .pl_idx_i     (pl_idx),
      .pl_ready_o   (pl_ready),
      .pc_valid_i   (pc_valid),
      .pc_idx_i     (pc_idx),
      .pc_ready_o   (pc_ready),
      .PL_en_o      (pl_en),
      .PC_en_o      (pc_en),
      .pos1_o       (pos[0]),
      .pos2_o       (pos[1]),
      .pos3_o       (pos[2]),
      .pos4_o       (pos[3]),
      .pos5_o       (pos[4]),
      .pos6_o       (pos[5]),
      .pos7_o       (pos[6]),
      .pos8_o       (pos[7]),
      .pos9_o       (pos[8]),
      .pos10_o      (pos[9]),
      .pos11_o      (pos[10]),
      .pos12_o      (pos[11]),
      .pos13_o      (pos[12]),
      .pos14_o      (pos[13]),
      .pos15_o      (pos[14]),
      .pos16_o      (pos[15]),
      .turn_o       (turn),
      .illegal_o    (illegal),
      .board_full_o (board_full),
      .timeout_o    (timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_board_empty(input string tag);
      logic [31:0] any = 0;
      for (int k = 0; k < 16; k++) any = any | {30'd0, pos[k]};
      check(tag, any, 32'd0);
   endtask

   // Issue one move, check its enable in the check cycle, then check the commit.
   task automatic move(input bit is_pc, input logic [3:0] idx);
      logic [15:0] oh;
      oh = 16'd1 << idx;
      @(negedge clk);
      if (is_pc) begin pc_valid = 1'b1; pc_idx = idx; end
      else       begin pl_valid = 1'b1; pl_idx = idx; end
      tick();
      check(is_pc ? "mv_pc_en" : "mv_pl_en", is_pc ? pc_en : pl_en, oh);
      @(negedge clk);
      pl_valid = 1'b0;
      pc_valid = 1'b0;
      tick();
      check("mv_pos", pos[idx], is_pc ? 2'b10 : 2'b01);
      check("mv_turn", turn, is_pc ? 1'b0 : 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0;
      pl_valid = 1'b0; pl_idx = '0; pc_valid = 1'b0; pc_idx = '0;

      // Reset state
      #12;
      check_board_empty("rst_pos");
      check("rst_en", {pl_en, pc_en}, 32'd0);
      check("rst_flags", {illegal, board_full, timeout, turn}, 32'd0);
      check("rst_ready", {pl_ready, pc_ready}, 32'b10);
      @(negedge clk);
      rst_n = 1'b1;

      // Player move to cell 5
      @(negedge clk);
      pl_valid = 1'b1; pl_idx = 4'd5;
      tick();
      check("p5_en", pl_en, 32'h0020);
      check("p5_pos_prewrite", pos[5], 2'b00);
      check("p5_ready_chk", {pl_ready, pc_ready}, 32'b00);
      @(negedge clk);
      pl_valid = 1'b0;
      tick();
      check("p5_en_gone", pl_en, 32'h0);
      check("p5_pos6", pos[5], 2'b01);
      check("p5_turn", turn, 1'b1);
      check("p5_pc_ready", pc_ready, 1'b1);
      check("p5_illegal", illegal, 1'b0);

      // Player request during computer turn is ignored
      @(negedge clk);
      pl_valid = 1'b1; pl_idx = 4'd2;
      tick();
      check("ign_pl_ready", pl_ready, 1'b0);
      check("ign_pl_en", pl_en, 32'h0);
      check("ign_pos3", pos[2], 2'b00);
      check("ign_pc_ready", pc_ready, 1'b1);
      @(negedge clk);
      pl_valid = 1'b0;

      // Computer onto occupied cell 5
      pc_valid = 1'b1; pc_idx = 4'd5;
      tick();
      check("occ_pc_en", pc_en, 32'h0020);
      check("occ_illegal_early", illegal, 1'b0);
      @(negedge clk);
      pc_valid = 1'b0;
      tick();
      check("occ_illegal", illegal, 1'b1);
      check("occ_pos6", pos[5], 2'b01);
      check("occ_turn", turn, 1'b1);
      check("occ_pc_ready", pc_ready, 1'b1);
      tick();
      check("occ_illegal_once", illegal, 1'b0);

      // Clear, then fill the board with alternating moves 0..15
      @(negedge clk);
      clear = 1'b1;
      tick();
      @(negedge clk);
      clear = 1'b0;
      check_board_empty("clr1_pos");
      check("clr1_turn", turn, 1'b0);
      for (int k = 0; k < 16; k++) begin
         if (k == 15) check("fill_not_full_yet", board_full, 1'b0);
         move(k[0], 4'(k));
      end
      check("full_flag", board_full, 1'b1);
      check("full_ready", {pl_ready, pc_ready}, 32'b00);
      check("full_pos1", pos[0], 2'b01);
      check("full_pos16", pos[15], 2'b10);
      check("full_pos9", pos[8], 2'b01);
      @(negedge clk);
      pl_valid = 1'b1; pl_idx = 4'd0;
      tick();
      check("full_ignore_en", pl_en, 32'h0);
      check("full_held", board_full, 1'b1);
      @(negedge clk);
      pl_valid = 1'b0;
      clear = 1'b1;
      tick();
      check_board_empty("clr2_pos");
      check("clr2_full", board_full, 1'b0);
      check("clr2_turn", turn, 1'b0);
      check("clr2_ready", {pl_ready, pc_ready}, 32'b10);
      @(negedge clk);
      clear = 1'b0;

      // Clear during PL_CHECK for cell 3 aborts the move
      pl_valid = 1'b1; pl_idx = 4'd3;
      tick();
      check("abort_en", pl_en, 32'h0008);
      @(negedge clk);
      pl_valid = 1'b0;
      clear = 1'b1;
      tick();
      check("abort_pos4", pos[3], 2'b00);
      check("abort_illegal", illegal, 1'b0);
      check("abort_ready", pl_ready, 1'b1);
      check("abort_turn", turn, 1'b0);
      check("abort_en_gone", pl_en, 32'h0);
      @(negedge clk);
      clear = 1'b0;

      // Idle player turn: this sample was PL_TURN cycle 1, cycles 2..8 follow
`ifdef MOVE_TIMEOUT_EN
      check("tmo_cyc1", timeout, 1'b0);
      for (int i = 2; i <= 8; i++) begin
         tick();
         check("tmo_pulse", timeout, (i == 8) ? 1'b1 : 1'b0);
      end
      tick();
      check("tmo_after", timeout, 1'b0);
      check("tmo_turn", turn, 1'b1);
      check("tmo_pc_ready", pc_ready, 1'b1);
      check_board_empty("tmo_pos");
`else
      for (int i = 2; i <= 10; i++) begin
         tick();
         check("notmo_pulse", timeout, 1'b0);
      end
      check("notmo_turn", turn, 1'b0);
      check("notmo_ready", pl_ready, 1'b1);
      check_board_empty("notmo_pos");
`endif

      // Async reset mid-check: no write, immediate reset values
`ifdef MOVE_TIMEOUT_EN
      move(1'b1, 4'd9);
`endif
      @(negedge clk);
      pl_valid = 1'b1; pl_idx = 4'd7;
      tick();
      check("rstchk_en", pl_en, 32'h0080);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstchk_en_zero", pl_en, 32'h0);
      check_board_empty("rstchk_pos");
      check("rstchk_turn", turn, 1'b0);
      pl_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rstchk_pos8", pos[7], 2'b00);
      check("rstchk_ready", pl_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
